// File: rtl/data_transmitter_if.sv
// Word-to-byte transmitter bus: result word in, byte strobe out to the UART TX.
// master is the environment (core + UART) side, slave is the transmitter.
interface data_transmitter_if;
  logic [31:0] in_data;
  logic        in_data_ready;
  logic        tx_busy;
  logic [7:0]  out_data;
  logic        out_data_ready;
  logic        busy;
  logic        overflow;

  modport master (
    output in_data, in_data_ready, tx_busy,
    input  out_data, out_data_ready, busy, overflow
  );

  modport slave (
    input  in_data, in_data_ready, tx_busy,
    output out_data, out_data_ready, busy, overflow
  );
endinterface

// File: rtl/data_transmitter.sv
// Serialises 32-bit result words into four MSB-first bytes paced by the UART
// busy flag, with one pending word slot behind the active word.
module data_transmitter #(
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned BYTES       = 4
) (
  input logic              clk,
  input logic              rst,
  data_transmitter_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0]  LAST_IDX = 2'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        active_q, active_d;
  logic [31:0]        pending_q, pending_d;
  logic               pending_valid_q, pending_valid_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               take_pend_d, start_new_d, pend_load_d;
  logic [1:0]         next_idx;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    sel_byte = w[31:24];
      2'd1:    sel_byte = w[23:16];
      2'd2:    sel_byte = w[15:8];
      default: sel_byte = w[7:0];
    endcase
  endfunction

  // A word parked in pending while the FSM drops to IDLE is started from IDLE
  // on the following cycle, so a strobe landing on the last WAIT_DONE cycle is never lost.
  always_comb begin
    next_idx    = byte_idx_q + 2'd1;
    take_pend_d = pending_valid_q &&
                  ((state_q == IDLE) ||
                   (state_q == WAIT_DONE && !bus.tx_busy && byte_idx_q == LAST_IDX));
    start_new_d = (state_q == IDLE) && !pending_valid_q && bus.in_data_ready;
    pend_load_d = bus.in_data_ready && !start_new_d && (!pending_valid_q || take_pend_d);
    overflow_d  = bus.in_data_ready && !start_new_d && pending_valid_q && !take_pend_d;
    pending_d       = pend_load_d ? bus.in_data : pending_q;
    pending_valid_d = pend_load_d || (pending_valid_q && !take_pend_d);

    state_d    = state_q;
    active_d   = active_q;
    byte_idx_d = byte_idx_q;
    wait_cnt_d = wait_cnt_q;
    out_data_d = out_data_q;
    strobe_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (take_pend_d || start_new_d) begin
          active_d   = take_pend_d ? pending_q : bus.in_data;
          byte_idx_d = '0;
          out_data_d = take_pend_d ? pending_q[31:24] : bus.in_data[31:24];
          strobe_d   = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy || wait_cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          wait_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_idx_q != LAST_IDX) begin
            byte_idx_d = next_idx;
            out_data_d = sel_byte(active_q, next_idx);
            strobe_d   = 1'b1;
            state_d    = WAIT_ACK;
          end else if (take_pend_d) begin
            active_d   = pending_q;
            byte_idx_d = '0;
            out_data_d = pending_q[31:24];
            strobe_d   = 1'b1;
            state_d    = WAIT_ACK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || pending_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      byte_idx_q      <= '0;
      wait_cnt_q      <= '0;
      out_data_q      <= '0;
      strobe_q        <= 1'b0;
      busy_q          <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      byte_idx_q      <= byte_idx_d;
      wait_cnt_q      <= wait_cnt_d;
      out_data_q      <= out_data_d;
      strobe_q        <= strobe_d;
      busy_q          <= busy_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.out_data       = out_data_q;
  assign bus.out_data_ready = strobe_q;
  assign bus.busy           = busy_q;
  assign bus.overflow       = overflow_q;

endmodule
